// File: rtl/dbus_wb_if_if.sv
// Wishbone B3 classic bus bundle for the data-side interface.
// The master drives address/data/controls; the slave returns read data and ack.
interface dbus_wb_if_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/dbus_wb_if.sv
// Data-side bus interface: turns a memory-stage load/store into one registered
// Wishbone classic cycle, stalling the pipeline and buffering load data.
module dbus_wb_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        bus_err_o,
  dbus_wb_if_if.master wb
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WAIT_FOR_STALL
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] rd_buf;
  logic [7:0]  cnt;
  logic        timeout_hit;

  assign timeout_hit = (cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rd_buf      <= '0;
      cnt         <= '0;
      bus_err_o   <= 1'b0;
      wb.wb_adr_o <= '0;
      wb.wb_dat_o <= '0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_sel_o <= '0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_cyc_o <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            wb.wb_adr_o <= cpu_addr_i;
            wb.wb_dat_o <= cpu_data_i;
            wb.wb_we_o  <= cpu_we_i;
            wb.wb_sel_o <= cpu_sel_i;
            wb.wb_stb_o <= 1'b1;
            wb.wb_cyc_o <= 1'b1;
            cnt         <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          // Every exit from BUSY clears the whole bus; flush outranks ack,
          // and ack outranks the timeout on the same cycle.
          if (flush_i || wb.wb_ack_i || timeout_hit) begin
            wb.wb_adr_o <= '0;
            wb.wb_dat_o <= '0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_sel_o <= '0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_cyc_o <= 1'b0;
          end
          if (flush_i) begin
            state <= IDLE;
          end else if (wb.wb_ack_i) begin
            if (!wb.wb_we_o) rd_buf <= wb.wb_dat_i;
            state <= (stall_i != '0) ? WAIT_FOR_STALL : IDLE;
          end else if (timeout_hit) begin
            bus_err_o <= 1'b1;
            rd_buf    <= '0;
            state     <= (stall_i != '0) ? WAIT_FOR_STALL : IDLE;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT_FOR_STALL: begin
          if (flush_i || stall_i == '0) begin
            rd_buf <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    case (state)
      IDLE:    stallreq_o = cpu_ce_i & ~flush_i;
      BUSY:    stallreq_o = ~wb.wb_ack_i & ~flush_i & ~timeout_hit;
      default: stallreq_o = 1'b0;
    endcase
  end

  // A flush coinciding with the ack suppresses the returned data.
  always_comb begin
    cpu_data_o = '0;
    if (state == BUSY && wb.wb_ack_i && !wb.wb_we_o && !flush_i)
      cpu_data_o = wb.wb_dat_i;
    else if (state == WAIT_FOR_STALL)
      cpu_data_o = rd_buf;
  end

endmodule

// File: tb/tb_dbus_wb_if.sv
// Directed self-checking bench for dbus_wb_if with a hand-driven Wishbone slave.
module tb_dbus_wb_if;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i, cpu_we_i, flush_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
  logic [3:0]  cpu_sel_i;
  logic [5:0]  stall_i;
  logic        stallreq_o, bus_err_o;
  int          passed = 0;
  int          total = 0;

  dbus_wb_if_if wb ();

  dbus_wb_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_sel_i(cpu_sel_i),
    .cpu_data_o(cpu_data_o), .stall_i(stall_i), .flush_i(flush_i),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o), .wb(wb)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 later.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic request(input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] sel);
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr;
    cpu_data_i = data; cpu_sel_i = sel;
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_ce_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_data_i = '0;
    cpu_sel_i = '0; stall_i = '0; flush_i = 0; wb.wb_ack_i = 0; wb.wb_dat_i = '0;
    tick(); tick(); settle();
    total++; if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0) $display("FAIL reset_cyc_stb got %b%b want 00", wb.wb_cyc_o, wb.wb_stb_o); else passed++;
    total++; if (wb.wb_adr_o !== 32'h0 || wb.wb_dat_o !== 32'h0 || wb.wb_sel_o !== 4'h0 || wb.wb_we_o !== 1'b0) $display("FAIL reset_bus got adr=%h dat=%h sel=%h we=%b want zeros", wb.wb_adr_o, wb.wb_dat_o, wb.wb_sel_o, wb.wb_we_o); else passed++;
    total++; if (stallreq_o !== 1'b0 || bus_err_o !== 1'b0 || cpu_data_o !== 32'h0) $display("FAIL reset_outputs got stallreq=%b err=%b data=%h want 0 0 0", stallreq_o, bus_err_o, cpu_data_o); else passed++;
    tick(); rst = 1'b1;
  endtask

  task automatic test_zero_wait_load();
    int stall_cnt = 0;
    tick(); request(1'b0, 32'h0000_0100, 32'h0, 4'hF); settle();
    if (stallreq_o) stall_cnt++;
    total++; if (stallreq_o !== 1'b1) $display("FAIL zw_req_stall got %b want 1", stallreq_o); else passed++;
    tick(); cpu_ce_i = 0; wb.wb_ack_i = 1; wb.wb_dat_i = 32'hDEADBEEF; settle();
    if (stallreq_o) stall_cnt++;
    total++; if (wb.wb_stb_o !== 1'b1 || wb.wb_adr_o !== 32'h100 || wb.wb_sel_o !== 4'hF || wb.wb_we_o !== 1'b0) $display("FAIL zw_bus got stb=%b adr=%h sel=%h we=%b want 1 100 f 0", wb.wb_stb_o, wb.wb_adr_o, wb.wb_sel_o, wb.wb_we_o); else passed++;
    total++; if (cpu_data_o !== 32'hDEADBEEF) $display("FAIL zw_data got %h want deadbeef", cpu_data_o); else passed++;
    tick(); wb.wb_ack_i = 0; wb.wb_dat_i = '0; settle();
    total++; if (stall_cnt !== 1) $display("FAIL zw_stall_cycles got %0d want 1", stall_cnt); else passed++;
    total++; if (wb.wb_cyc_o !== 1'b0 || stallreq_o !== 1'b0 || cpu_data_o !== 32'h0) $display("FAIL zw_idle got cyc=%b stallreq=%b data=%h want 0 0 0", wb.wb_cyc_o, stallreq_o, cpu_data_o); else passed++;
  endtask

  task automatic test_store_wait_states();
    int stall_cnt = 0;
    tick(); request(1'b1, 32'h0000_0204, 32'h1234_5678, 4'h3); settle();
    if (stallreq_o) stall_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick(); cpu_ce_i = 0; wb.wb_ack_i = (i == 3); settle();
      if (stallreq_o) stall_cnt++;
      total++; if (wb.wb_we_o !== 1'b1 || wb.wb_sel_o !== 4'h3 || wb.wb_dat_o !== 32'h12345678 || wb.wb_adr_o !== 32'h204 || wb.wb_cyc_o !== 1'b1 || wb.wb_stb_o !== 1'b1)
        $display("FAIL st_hold[%0d] got we=%b sel=%h dat=%h adr=%h cyc=%b stb=%b want 1 3 12345678 204 1 1", i, wb.wb_we_o, wb.wb_sel_o, wb.wb_dat_o, wb.wb_adr_o, wb.wb_cyc_o, wb.wb_stb_o); else passed++;
    end
    total++; if (cpu_data_o !== 32'h0) $display("FAIL st_no_data got %h want 0", cpu_data_o); else passed++;
    tick(); wb.wb_ack_i = 0; settle();
    total++; if (stall_cnt !== 4) $display("FAIL st_stall_cycles got %0d want 4", stall_cnt); else passed++;
    total++; if (wb.wb_cyc_o !== 1'b0 || wb.wb_we_o !== 1'b0 || wb.wb_dat_o !== 32'h0) $display("FAIL st_release got cyc=%b we=%b dat=%h want 0 0 0", wb.wb_cyc_o, wb.wb_we_o, wb.wb_dat_o); else passed++;
  endtask

  task automatic test_wait_for_stall();
    tick(); request(1'b0, 32'h0000_0300, 32'h0, 4'hF);
    tick(); cpu_ce_i = 0; wb.wb_ack_i = 1; wb.wb_dat_i = 32'hA5A5_0001; stall_i = 6'b000011; settle();
    total++; if (cpu_data_o !== 32'hA5A50001) $display("FAIL ws_ack_data got %h want a5a50001", cpu_data_o); else passed++;
    tick(); wb.wb_ack_i = 0; wb.wb_dat_i = 32'hFFFF_FFFF; settle();
    total++; if (cpu_data_o !== 32'hA5A50001 || stallreq_o !== 1'b0 || wb.wb_cyc_o !== 1'b0) $display("FAIL ws_hold1 got data=%h stallreq=%b cyc=%b want a5a50001 0 0", cpu_data_o, stallreq_o, wb.wb_cyc_o); else passed++;
    tick(); stall_i = '0; settle();
    total++; if (cpu_data_o !== 32'hA5A50001) $display("FAIL ws_hold2 got %h want a5a50001", cpu_data_o); else passed++;
    tick(); wb.wb_dat_i = '0; settle();
    total++; if (cpu_data_o !== 32'h0) $display("FAIL ws_release got %h want 0", cpu_data_o); else passed++;
    cpu_ce_i = 1; cpu_we_i = 0; settle();
    total++; if (stallreq_o !== 1'b1) $display("FAIL ws_idle_accept got stallreq=%b want 1", stallreq_o); else passed++;
    cpu_ce_i = 0;
  endtask

  task automatic test_flush();
    tick(); request(1'b0, 32'h0000_0400, 32'h0, 4'hF);
    tick(); cpu_ce_i = 0;
    tick();
    tick(); flush_i = 1; settle();
    total++; if (stallreq_o !== 1'b0 || cpu_data_o !== 32'h0) $display("FAIL fl_flush_cycle got stallreq=%b data=%h want 0 0", stallreq_o, cpu_data_o); else passed++;
    tick(); flush_i = 0; wb.wb_ack_i = 1; wb.wb_dat_i = 32'hCAFE_F00D; settle();
    total++; if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0 || wb.wb_adr_o !== 32'h0) $display("FAIL fl_drop got cyc=%b stb=%b adr=%h want 0 0 0", wb.wb_cyc_o, wb.wb_stb_o, wb.wb_adr_o); else passed++;
    total++; if (cpu_data_o !== 32'h0 || bus_err_o !== 1'b0 || stallreq_o !== 1'b0) $display("FAIL fl_late_ack got data=%h err=%b stallreq=%b want 0 0 0", cpu_data_o, bus_err_o, stallreq_o); else passed++;
    tick(); wb.wb_ack_i = 0; wb.wb_dat_i = '0; settle();
    total++; if (cpu_data_o !== 32'h0 || bus_err_o !== 1'b0 || wb.wb_cyc_o !== 1'b0) $display("FAIL fl_after got data=%h err=%b cyc=%b want 0 0 0", cpu_data_o, bus_err_o, wb.wb_cyc_o); else passed++;
  endtask

  task automatic test_timeout();
    tick(); request(1'b0, 32'h0000_0500, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      tick(); cpu_ce_i = 0; settle();
      total++; if (wb.wb_cyc_o !== 1'b1 || bus_err_o !== 1'b0 || stallreq_o !== (i != 3)) $display("FAIL to_busy[%0d] got cyc=%b err=%b stallreq=%b want 1 0 %b", i, wb.wb_cyc_o, bus_err_o, stallreq_o, (i != 3)); else passed++;
    end
    tick(); settle();
    total++; if (bus_err_o !== 1'b1 || wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0 || stallreq_o !== 1'b0 || cpu_data_o !== 32'h0) $display("FAIL to_abort got err=%b cyc=%b stb=%b stallreq=%b data=%h want 1 0 0 0 0", bus_err_o, wb.wb_cyc_o, wb.wb_stb_o, stallreq_o, cpu_data_o); else passed++;
    tick(); settle();
    total++; if (bus_err_o !== 1'b0) $display("FAIL to_pulse_width got err=%b want 0", bus_err_o); else passed++;
  endtask

  task automatic test_reset_mid_busy();
    tick(); request(1'b1, 32'h0000_0600, 32'h5555_AAAA, 4'hC);
    tick(); cpu_ce_i = 0; rst = 0; settle();
    total++; if (wb.wb_cyc_o !== 1'b1) $display("FAIL rb_busy got cyc=%b want 1", wb.wb_cyc_o); else passed++;
    tick(); rst = 1; settle();
    total++; if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0 || wb.wb_we_o !== 1'b0 || wb.wb_adr_o !== 32'h0 || wb.wb_dat_o !== 32'h0 || wb.wb_sel_o !== 4'h0)
      $display("FAIL rb_bus got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h want zeros", wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_adr_o, wb.wb_dat_o, wb.wb_sel_o); else passed++;
    total++; if (stallreq_o !== 1'b0 || bus_err_o !== 1'b0 || cpu_data_o !== 32'h0) $display("FAIL rb_outputs got stallreq=%b err=%b data=%h want 0 0 0", stallreq_o, bus_err_o, cpu_data_o); else passed++;
    tick(); settle();
    total++; if (wb.wb_cyc_o !== 1'b0 || stallreq_o !== 1'b0) $display("FAIL rb_idle got cyc=%b stallreq=%b want 0 0", wb.wb_cyc_o, stallreq_o); else passed++;
  endtask

  task automatic test_back_to_back();
    tick(); request(1'b0, 32'h0000_0700, 32'h0, 4'h1);
    tick(); wb.wb_ack_i = 1; wb.wb_dat_i = 32'h0000_0011; settle();
    total++; if (cpu_data_o !== 32'h11 || wb.wb_sel_o !== 4'h1) $display("FAIL b2b_first got data=%h sel=%h want 11 1", cpu_data_o, wb.wb_sel_o); else passed++;
    tick(); wb.wb_ack_i = 0; request(1'b0, 32'h0000_0704, 32'h0, 4'h2); settle();
    total++; if (stallreq_o !== 1'b1 || wb.wb_cyc_o !== 1'b0) $display("FAIL b2b_gap got stallreq=%b cyc=%b want 1 0", stallreq_o, wb.wb_cyc_o); else passed++;
    tick(); cpu_ce_i = 0; wb.wb_ack_i = 1; wb.wb_dat_i = 32'h0000_2200; settle();
    total++; if (cpu_data_o !== 32'h2200 || wb.wb_adr_o !== 32'h704 || wb.wb_sel_o !== 4'h2) $display("FAIL b2b_second got data=%h adr=%h sel=%h want 2200 704 2", cpu_data_o, wb.wb_adr_o, wb.wb_sel_o); else passed++;
    tick(); wb.wb_ack_i = 0; wb.wb_dat_i = '0;
  endtask

  initial begin
    test_reset();
    test_zero_wait_load();
    test_store_wait_states();
    test_wait_for_stall();
    test_flush();
    test_timeout();
    test_reset_mid_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dbus_wb_if.md
# dbus_wb_if

Data-side bus interface between the memory-access stage and a Wishbone B3 classic slave. It converts the single-cycle load/store request from the memory-access stage into a registered Wishbone cycle. While the bus is busy it holds the pipeline through `stallreq_o`. It holds returned load data until the pipeline controller releases the stall, and it aborts cleanly on `flush_i`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: number of BUSY cycles without `wb_ack_i` before the interface aborts with a bus error. Legal range is 1..255; the counter is 8 bits wide.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-low. A low level on the rising edge of `clk` resets the block.
- `cpu_ce_i`  in  1  memory-access stage request valid.
- `cpu_we_i`  in  1  1 = store, 0 = load.
- `cpu_addr_i`  in  32  byte address.
- `cpu_data_i`  in  32  store data.
- `cpu_sel_i`  in  4  byte lane selects.
- `cpu_data_o`  out  32  load data returned to the memory-access stage.
- `stall_i`  in  6  pipeline stall vector from the controller; bit 0 is PC, bit 5 is write-back.
- `flush_i`  in  1  pipeline flush (exception or eret).
- `stallreq_o`  out  1  stall request to the controller.
- `bus_err_o`  out  1  one-cycle pulse when a transfer times out.
- `wb_adr_o`  out  32  Wishbone address (registered).
- `wb_dat_o`  out  32  Wishbone write data (registered).
- `wb_dat_i`  in  32  Wishbone read data.
- `wb_we_o`  out  1  Wishbone write enable (registered).
- `wb_sel_o`  out  4  Wishbone byte selects (registered).
- `wb_stb_o`  out  1  Wishbone strobe (registered).
- `wb_cyc_o`  out  1  Wishbone cycle (registered).
- `wb_ack_i`  in  1  Wishbone acknowledge.

## Operation
- States: IDLE, BUSY, WAIT_FOR_STALL. Reset state is IDLE.
- Reset values:
  - All `wb_*` outputs are 0.
  - `rd_buf` is 0 and the timeout counter is 0.
  - `bus_err_o` is 0.
- IDLE:
  - If `cpu_ce_i` = 1 and `flush_i` = 0, the block registers `adr`/`dat`/`we`/`sel` from the cpu inputs, sets `cyc` = `stb` = 1, clears the counter and moves to BUSY.
  - Otherwise it stays in IDLE.
- BUSY, checked in priority order:
  - `flush_i` = 1: drop `cyc`/`stb`, zero `adr`/`dat`/`we`/`sel`, go to IDLE. A late ack is ignored.
  - `wb_ack_i` = 1: drop all `wb_*` outputs to 0. For a load, `rd_buf` <= `wb_dat_i`. If `stall_i` != 0, go to WAIT_FOR_STALL; otherwise go to IDLE.
  - Counter = `TIMEOUT_CYCLES`-1: drop all `wb_*` outputs, pulse `bus_err_o` for the next cycle, set `rd_buf` <= 0, go to WAIT_FOR_STALL if `stall_i` != 0, else IDLE.
  - Otherwise: counter increments by 1 (8-bit, saturating at 255).
- WAIT_FOR_STALL:
  - If `flush_i` = 1, or `stall_i` = 0: go to IDLE and clear `rd_buf`.
- `stallreq_o` (combinational):
  - IDLE: `cpu_ce_i & ~flush_i`.
  - BUSY: `~wb_ack_i & ~flush_i & ~timeout_hit`.
  - WAIT_FOR_STALL: 0.
- `cpu_data_o` (combinational):
  - BUSY with `wb_ack_i` and a load: `wb_dat_i`.
  - WAIT_FOR_STALL: `rd_buf`.
  - Otherwise: 0.
- A new request is accepted only in IDLE, so at most one transfer is outstanding.

## Timing
- Minimum latency is 2 cycles.
  - Cycle 0: request seen in IDLE, `stallreq_o` = 1.
  - Cycle 1: BUSY with `stb` = 1. With a zero-wait ack, `cpu_data_o` is valid and `stallreq_o` = 0 in the same cycle.
- Each wait state from the slave adds one cycle; `stallreq_o` stays high throughout.
- `wb_stb_o` and `wb_cyc_o` are always asserted and deasserted together. They never deassert while BUSY except on ack, flush or timeout.
- `flush_i` together with `cpu_ce_i` in IDLE: no cycle is started.
- `flush_i` together with `wb_ack_i` in BUSY: flush wins and no data is returned.
- Reset in any state: IDLE next cycle, all outputs at their reset values, any in-flight cycle abandoned.

## Test plan
- Zero-wait load: request `addr` 0x0000_0100, `sel` 0xF; slave acks in the first `stb` cycle with 0xDEADBEEF. Required: `stallreq_o` high for exactly 1 cycle, `cpu_data_o` = 0xDEADBEEF in the ack cycle, FSM back in IDLE.
- Store with 3 wait states: `addr` 0x0000_0204, `data` 0x1234_5678, `sel` 0x3. Required: `wb_we_o` = 1, `wb_sel_o` = 0x3, `wb_dat_o` = 0x12345678 held stable for 4 cycles; `stallreq_o` high for 4 cycles in total.
- Load acked while `stall_i` = 6'b000011 for 2 more cycles, data 0xA5A5_0001. Required: FSM in WAIT_FOR_STALL, `cpu_data_o` = 0xA5A50001 for those 2 cycles, then 0 and IDLE.
- Flush during BUSY after 2 wait states, with ack arriving 1 cycle later. Required: `cyc`/`stb` = 0 on the cycle after the flush, the late ack is ignored, `cpu_data_o` = 0, no `bus_err_o`.
- `TIMEOUT_CYCLES` = 4 and the slave never acks. Required: `bus_err_o` pulses once after 4 BUSY cycles, `cyc` drops, `stallreq_o` falls, `cpu_data_o` = 0.
- `rst` = 0 asserted mid-BUSY. Required: the next cycle has all `wb_*` outputs = 0, `stallreq_o` = 0 with `cpu_ce_i` = 0, and the FSM in IDLE.
